// File: rtl/fetch_pkg.sv
// Shared fetch-side constants and fill FSM encoding for the instruction-cache fill path.
package fetch_pkg;
  localparam int BLOCK_SIZE    = 32;
  localparam int BITS_PER_BYTE = 8;
  localparam int BEAT_BITS     = 64;
  localparam int BLOCK_BITS    = BLOCK_SIZE * BITS_PER_BYTE;
  localparam int BEATS         = BLOCK_BITS / BEAT_BITS;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DRAIN = 3'd4
  } fill_state_e;
endpackage

// File: rtl/fill_block_buffer.sv
// Beat-indexed block assembly register: one beat written per strobe, whole block cleared on new fill.
module fill_block_buffer #(
  parameter int BEATS     = 4,
  parameter int BEAT_BITS = 64,
  parameter int IDX_W     = 2
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       clr_i,
  input  logic                       we_i,
  input  logic [IDX_W-1:0]           idx_i,
  input  logic [BEAT_BITS-1:0]       data_i,
  output logic [BEATS*BEAT_BITS-1:0] block_o
);
  logic [BEATS-1:0][BEAT_BITS-1:0] beat_q;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      beat_q <= '0;
    end else if (clr_i) begin
      beat_q <= '0;
    end else if (we_i) begin
      for (int i = 0; i < BEATS; i++)
        if (idx_i == IDX_W'(i)) beat_q[i] <= data_i;
    end
  end

  assign block_o = beat_q;
endmodule

// File: rtl/icache_fill.sv
// Instruction-cache miss fill: fetches a block beat by beat from memory and writes it to the cache once.
module icache_fill #(
  parameter int BLOCK_SIZE    = fetch_pkg::BLOCK_SIZE,
  parameter int BITS_PER_BYTE = fetch_pkg::BITS_PER_BYTE,
  parameter int BEAT_BITS     = fetch_pkg::BEAT_BITS
) (
  input  logic                                clock_i,
  input  logic                                reset_i,
  input  logic                                missValid_i,
  input  logic [15:0]                         missAddr_i,
  output logic                                missReady_o,
  input  logic                                flush_i,
  output logic                                memReq_o,
  output logic [15:0]                         memAddr_o,
  input  logic                                memAck_i,
  input  logic                                memValid_i,
  input  logic [BEAT_BITS-1:0]                memData_i,
  output logic                                writeEnable_o,
  output logic [15:0]                         writeAddress_o,
  output logic [BLOCK_SIZE*BITS_PER_BYTE-1:0] writeBlock_o,
  output logic                                busy_o
);
  import fetch_pkg::*;

  localparam int BLK_BITS   = BLOCK_SIZE * BITS_PER_BYTE;
  localparam int NBEATS     = BLK_BITS / BEAT_BITS;
  localparam int BEAT_W     = $clog2(NBEATS);
  localparam int BEAT_BYTES = BEAT_BITS / BITS_PER_BYTE;
  localparam logic [15:0] BASE_MASK = ~16'(BLOCK_SIZE - 1);

  fill_state_e       state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [15:0]       base_q, base_d;
  logic              clr, cap;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    base_d  = base_q;
    clr     = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      S_IDLE:
        if (missValid_i && !flush_i) begin
          base_d  = missAddr_i & BASE_MASK;
          beat_d  = '0;
          clr     = 1'b1;
          state_d = S_REQ;
        end
      S_REQ:
        if (memAck_i) begin
          // Data already returned with a flush leaves nothing outstanding, so no drain needed.
          if (memValid_i) begin
            if (flush_i) state_d = S_IDLE;
            else         cap     = 1'b1;
          end else begin
            state_d = flush_i ? S_DRAIN : S_WAIT;
          end
        end else if (flush_i) begin
          state_d = S_IDLE;
        end
      S_WAIT:
        if (memValid_i) begin
          if (flush_i) state_d = S_IDLE;
          else         cap     = 1'b1;
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      S_WRITE: state_d = S_IDLE;
      S_DRAIN: if (memValid_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (cap) begin
      beat_d  = beat_q + 1'b1;
      state_d = (beat_q == BEAT_W'(NBEATS - 1)) ? S_WRITE : S_REQ;
    end
  end

  fill_block_buffer #(
    .BEATS    (NBEATS),
    .BEAT_BITS(BEAT_BITS),
    .IDX_W    (BEAT_W)
  ) u_buf (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .clr_i  (clr),
    .we_i   (cap),
    .idx_i  (beat_q),
    .data_i (memData_i),
    .block_o(writeBlock_o)
  );

  // Base is block-aligned and beat offset stays inside the block, so no carry reaches the tag bits.
  assign memAddr_o      = base_q + 16'(beat_q) * 16'(BEAT_BYTES);
  assign memReq_o       = (state_q == S_REQ);
  assign missReady_o    = (state_q == S_IDLE);
  assign busy_o         = (state_q != S_IDLE);
  assign writeEnable_o  = (state_q == S_WRITE) && !flush_i;
  assign writeAddress_o = base_q;
endmodule

// File: tb/tb_icache_fill.sv
// Scoreboard bench for icache_fill: stimulus queues expected beat addresses and block writes, a monitor checks them.
module tb_icache_fill;
  logic         clock_i = 1'b0;
  logic         reset_i;
  logic         missValid_i;
  logic [15:0]  missAddr_i;
  logic         missReady_o;
  logic         flush_i;
  logic         memReq_o;
  logic [15:0]  memAddr_o;
  logic         memAck_i;
  logic         memValid_i;
  logic [63:0]  memData_i;
  logic         writeEnable_o;
  logic [15:0]  writeAddress_o;
  logic [255:0] writeBlock_o;
  logic         busy_o;

  typedef struct {
    logic [15:0]  addr;
    logic [255:0] blk;
  } wr_t;

  wr_t         exp_wr_q[$];
  logic [15:0] exp_addr_q[$];
  int          checks = 0;
  int          fails  = 0;

  icache_fill dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .missValid_i(missValid_i), .missAddr_i(missAddr_i), .missReady_o(missReady_o),
    .flush_i(flush_i),
    .memReq_o(memReq_o), .memAddr_o(memAddr_o), .memAck_i(memAck_i),
    .memValid_i(memValid_i), .memData_i(memData_i),
    .writeEnable_o(writeEnable_o), .writeAddress_o(writeAddress_o),
    .writeBlock_o(writeBlock_o), .busy_o(busy_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: beat address while requesting, block contents on every write strobe.
  always @(negedge clock_i) begin
    if (memReq_o) begin
      if (exp_addr_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_memReq: got addr %0h expected no request (t=%0t)", memAddr_o, $time);
      end else begin
        check("memAddr", memAddr_o, exp_addr_q[0]);
        if (memAck_i) void'(exp_addr_q.pop_front());
      end
    end
    if (writeEnable_o) begin
      if (exp_wr_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_write: got addr %0h expected no write (t=%0t)", writeAddress_o, $time);
      end else begin
        wr_t e;
        e = exp_wr_q.pop_front();
        check("writeAddress", writeAddress_o, e.addr);
        check("writeBlock", writeBlock_o, e.blk);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock_i); #1;
  endtask

  task automatic push_addrs(input logic [15:0] base, input int n);
    for (int b = 0; b < n; b++) exp_addr_q.push_back(base + 16'(8 * b));
  endtask

  task automatic accept(input logic [15:0] a);
    missValid_i = 1'b1; missAddr_i = a;
    tick();
    missValid_i = 1'b0;
  endtask

  // Junk valid data while the request is still unacknowledged must be ignored.
  task automatic beat(input int ack_dly, input int vld_dly, input logic [63:0] d);
    repeat (ack_dly) begin
      memValid_i = 1'b1; memData_i = 64'hBAD0BAD0BAD0BAD0;
      tick();
    end
    memValid_i = 1'b0;
    memAck_i   = 1'b1;
    if (vld_dly == 0) begin memValid_i = 1'b1; memData_i = d; end
    tick();
    memAck_i = 1'b0; memValid_i = 1'b0;
    if (vld_dly > 0) begin
      repeat (vld_dly - 1) tick();
      memValid_i = 1'b1; memData_i = d;
      tick();
      memValid_i = 1'b0;
    end
  endtask

  task automatic fill(input logic [15:0] a, input int ack_dly, input int vld_dly,
                      input logic [63:0] d0, input logic [63:0] d1,
                      input logic [63:0] d2, input logic [63:0] d3);
    accept(a);
    beat(ack_dly, vld_dly, d0);
    beat(ack_dly, vld_dly, d1);
    beat(ack_dly, vld_dly, d2);
    beat(ack_dly, vld_dly, d3);
  endtask

  initial begin
    reset_i = 1'b0; missValid_i = 1'b0; missAddr_i = '0; flush_i = 1'b0;
    memAck_i = 1'b0; memValid_i = 1'b0; memData_i = '0;
    #2;
    check("rst_missReady", missReady_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_memReq", memReq_o, 1'b0);
    check("rst_memAddr", memAddr_o, 16'h0);
    check("rst_writeEnable", writeEnable_o, 1'b0);
    check("rst_writeBlock", writeBlock_o, 256'h0);
    tick();
    reset_i = 1'b1;
    tick();

    // Back-to-back beats: write appears in the 5th cycle after accept.
    push_addrs(16'h0040, 4);
    exp_wr_q.push_back('{16'h0040,
      256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111});
    fill(16'h0047, 0, 0, 64'h1111111111111111, 64'h2222222222222222,
         64'h3333333333333333, 64'h4444444444444444);
    check("latency_writeEnable", writeEnable_o, 1'b1);
    check("latency_writeAddress", writeAddress_o, 16'h0040);
    tick();
    check("after_write_busy", busy_o, 1'b0);

    // Slow memory: ack 3 cycles late, data 2 cycles after ack.
    push_addrs(16'h0120, 4);
    exp_wr_q.push_back('{16'h0120,
      256'h1F1E1D1C1B1A1918_1716151413121110_0F0E0D0C0B0A0908_0706050403020100});
    fill(16'h0123, 3, 2, 64'h0706050403020100, 64'h0F0E0D0C0B0A0908,
         64'h1716151413121110, 64'h1F1E1D1C1B1A1918);
    tick();

    // Flush in WAIT of beat 2, then drain one beat, then refill at 0x1000.
    push_addrs(16'h2000, 3);
    accept(16'h2010);
    beat(0, 2, 64'hAAAAAAAAAAAAAAAA);
    beat(0, 2, 64'hBBBBBBBBBBBBBBBB);
    memAck_i = 1'b1; tick(); memAck_i = 1'b0;
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    check("drain_busy", busy_o, 1'b1);
    check("drain_memReq", memReq_o, 1'b0);
    check("drain_missReady", missReady_o, 1'b0);
    memValid_i = 1'b1; memData_i = 64'hCCCCCCCCCCCCCCCC; tick(); memValid_i = 1'b0;
    check("post_drain_busy", busy_o, 1'b0);
    check("post_drain_missReady", missReady_o, 1'b1);
    push_addrs(16'h1000, 4);
    exp_wr_q.push_back('{16'h1000,
      256'hD0D1D2D3D4D5D6D7_C0C1C2C3C4C5C6C7_B0B1B2B3B4B5B6B7_A0A1A2A3A4A5A6A7});
    fill(16'h1000, 0, 1, 64'hA0A1A2A3A4A5A6A7, 64'hB0B1B2B3B4B5B6B7,
         64'hC0C1C2C3C4C5C6C7, 64'hD0D1D2D3D4D5D6D7);
    tick();

    // Miss together with flush in IDLE is refused.
    missValid_i = 1'b1; missAddr_i = 16'h3456; flush_i = 1'b1;
    tick();
    missValid_i = 1'b0; flush_i = 1'b0;
    check("flush_idle_missReady", missReady_o, 1'b1);
    check("flush_idle_memReq", memReq_o, 1'b0);
    check("flush_idle_busy", busy_o, 1'b0);

    // Flush in REQ before any ack returns straight to IDLE.
    push_addrs(16'h0500, 1);
    accept(16'h0500);
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    void'(exp_addr_q.pop_front());
    check("flush_req_busy", busy_o, 1'b0);

    // Flush during WRITE suppresses the strobe.
    push_addrs(16'h0600, 4);
    fill(16'h0600, 0, 0, 64'h1, 64'h2, 64'h3, 64'h4);
    flush_i = 1'b1; #1;
    check("flush_write_we", writeEnable_o, 1'b0);
    tick(); flush_i = 1'b0;
    check("flush_write_busy", busy_o, 1'b0);

    // Asynchronous reset mid-beat 1 clears everything before the next edge.
    push_addrs(16'h3000, 2);
    accept(16'h3000);
    beat(0, 0, 64'h5555555555555555);
    memAck_i = 1'b1; tick(); memAck_i = 1'b0;
    #2 reset_i = 1'b0;
    #1;
    check("arst_busy", busy_o, 1'b0);
    check("arst_memReq", memReq_o, 1'b0);
    check("arst_memAddr", memAddr_o, 16'h0);
    check("arst_missReady", missReady_o, 1'b1);
    check("arst_writeBlock", writeBlock_o, 256'h0);
    check("arst_writeAddress", writeAddress_o, 16'h0);
    tick();
    reset_i = 1'b1;
    memValid_i = 1'b1; memData_i = 64'h6666666666666666; tick(); memValid_i = 1'b0;
    repeat (4) tick();
    check("arst_release_busy", busy_o, 1'b0);

    // Top-of-memory block: addresses stop at 0xFFF8.
    push_addrs(16'hFFE0, 4);
    exp_wr_q.push_back('{16'hFFE0,
      256'h0123456789ABCDEF_FEDCBA9876543210_0F0F0F0F0F0F0F0F_F0F0F0F0F0F0F0F0});
    fill(16'hFFFD, 1, 0, 64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F,
         64'hFEDCBA9876543210, 64'h0123456789ABCDEF);
    repeat (3) tick();

    check("pending_writes", 32'(exp_wr_q.size()), 32'd0);
    check("pending_addrs", 32'(exp_addr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
